// File: rtl/mem_pkg.sv
// Shared types and helpers for the multi-port byte memory: write FSM states,
// default lane/count widths and the write-size legality check.
package mem_pkg;

   typedef enum logic [1:0] {
      MEM_WR_IDLE,
      MEM_WR_WRITE,
      MEM_WR_DONE
   } mem_wr_state_e;

   localparam int MEM_DATA_W_DEF = 32;
   localparam int MEM_LANES_DEF  = MEM_DATA_W_DEF / 8;
   localparam int MEM_CNT_W_DEF  = $clog2(MEM_LANES_DEF) + 1;

   // Legal write sizes are non-zero powers of two no wider than the word.
   function automatic logic mem_size_legal(input int unsigned nbytes, input int unsigned lanes);
      return (nbytes != 0) && ((nbytes & (nbytes - 1)) == 0) && (nbytes <= lanes);
   endfunction

endpackage

// File: rtl/mem_read_port.sv
// One registered read port: wraps the byte address into the store and gathers
// DATA_W/8 consecutive bytes little-endian into rd_data one cycle later.
module mem_read_port
   import mem_pkg::*;
#(
   parameter int DATA_W      = MEM_DATA_W_DEF,
   parameter int ADDR_W      = 32,
   parameter int DEPTH_BYTES = 4096
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic [7:0]        mem [DEPTH_BYTES],
   output logic [DATA_W-1:0] rd_data
);

   localparam int LANES = DATA_W / 8;
   localparam int IDX_W = $clog2(DEPTH_BYTES);

   logic [IDX_W-1:0]  base;
   logic [DATA_W-1:0] word;
   logic              unused_addr_hi;

   assign base           = addr[IDX_W-1:0];
   assign unused_addr_hi = ^addr[ADDR_W-1:IDX_W];

   // Index arithmetic is IDX_W wide so words straddling the top wrap to 0.
   always_comb begin
      word = '0;
      for (int i = 0; i < LANES; i++)
         word[i*8 +: 8] = mem[base + IDX_W'(i)];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_data <= '0;
      else        rd_data <= word;
   end

endmodule

// File: rtl/multiport_byte_memory.sv
// Byte-addressable little-endian store with NUM_RD registered read ports and a
// multi-cycle write engine. Define MEM_MISALIGN_FAULT_EN to reject misaligned writes.
module multiport_byte_memory
   import mem_pkg::*;
#(
   parameter int DATA_W          = MEM_DATA_W_DEF,
   parameter int ADDR_W          = 32,
   parameter int DEPTH_BYTES     = 4096,
   parameter int NUM_RD          = 2,
   parameter int BYTES_PER_CYCLE = 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
   output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data,
   input  logic                           wr_valid,
   input  logic [$clog2(DATA_W/8):0]      wr_bytes,
   input  logic [ADDR_W-1:0]              wr_addr,
   input  logic [DATA_W-1:0]              wr_data,
   output logic                           wr_busy,
   output logic                           wr_done,
   output logic                           wr_fault
);

   localparam int LANES = DATA_W / 8;
   localparam int CNT_W = $clog2(LANES) + 1;
   localparam int IDX_W = $clog2(DEPTH_BYTES);

   logic [7:0] data [DEPTH_BYTES];

   mem_wr_state_e     state, state_nxt;
   logic [IDX_W-1:0]  lat_addr;
   logic [DATA_W-1:0] lat_data;
   logic [CNT_W-1:0]  lat_rem;
   logic              lat_fault;
   logic              req, req_ok, misalign, last;
   logic              unused_wr_hi;

   assign unused_wr_hi = ^wr_addr[ADDR_W-1:IDX_W];
   assign req          = wr_valid && (wr_bytes != '0);

`ifdef MEM_MISALIGN_FAULT_EN
   assign misalign = (wr_addr[IDX_W-1:0] & IDX_W'(wr_bytes - CNT_W'(1))) != '0;
`else
   assign misalign = 1'b0;
`endif

   assign req_ok = mem_size_legal(32'(wr_bytes), LANES) && !misalign;
   assign last   = lat_rem <= CNT_W'(BYTES_PER_CYCLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= MEM_WR_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         MEM_WR_IDLE:  if (req) state_nxt = req_ok ? MEM_WR_WRITE : MEM_WR_DONE;
         MEM_WR_WRITE: if (last) state_nxt = MEM_WR_DONE;
         MEM_WR_DONE:  state_nxt = MEM_WR_IDLE;
         default:      state_nxt = MEM_WR_IDLE;
      endcase
   end

   assign wr_busy  = state != MEM_WR_IDLE;
   assign wr_done  = state == MEM_WR_DONE;
   assign wr_fault = wr_done && lat_fault;

   // Latched request; during WRITE it slides forward so byte 0 is always next.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_addr  <= '0;
         lat_data  <= '0;
         lat_rem   <= '0;
         lat_fault <= 1'b0;
      end else if (state == MEM_WR_IDLE && req) begin
         lat_addr  <= wr_addr[IDX_W-1:0];
         lat_data  <= wr_data;
         lat_rem   <= wr_bytes;
         lat_fault <= !req_ok;
      end else if (state == MEM_WR_WRITE) begin
         lat_addr <= lat_addr + IDX_W'(BYTES_PER_CYCLE);
         lat_data <= lat_data >> (8 * BYTES_PER_CYCLE);
         lat_rem  <= last ? '0 : lat_rem - CNT_W'(BYTES_PER_CYCLE);
      end
   end

   // Storage is deliberately outside reset so a preloaded image survives.
   always_ff @(posedge clk) begin
      if (state == MEM_WR_WRITE)
         for (int i = 0; i < BYTES_PER_CYCLE; i++)
            if (CNT_W'(i) < lat_rem)
               data[lat_addr + IDX_W'(i)] <= lat_data[i*8 +: 8];
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      mem_read_port #(
         .DATA_W      (DATA_W),
         .ADDR_W      (ADDR_W),
         .DEPTH_BYTES (DEPTH_BYTES)
      ) u_rd (
         .clk     (clk),
         .rst_n   (rst_n),
         .addr    (rd_addr[p]),
         .mem     (data),
         .rd_data (rd_data[p])
      );
   end

endmodule

// File: tb/tb_multiport_byte_memory.sv
// Self-checking bench for multiport_byte_memory: directed vector table, hand
// sequences for no-op/reset/wrap, and randomized writes against a byte-array model.
module tb_multiport_byte_memory;

   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int DEPTH = 4096;
   localparam int NRD   = 2;
   localparam int BPC   = 1;
`ifdef MEM_MISALIGN_FAULT_EN
   localparam bit MIS = 1'b1;
`else
   localparam bit MIS = 1'b0;
`endif

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic [NRD-1:0][AW-1:0]   rd_addr;
   logic [NRD-1:0][DW-1:0]   rd_data;
   logic                     wr_valid;
   logic [2:0]               wr_bytes;
   logic [AW-1:0]            wr_addr;
   logic [DW-1:0]            wr_data;
   logic                     wr_busy, wr_done, wr_fault;

   int checks = 0;
   int errors = 0;

   logic [7:0] mm    [DEPTH];
   bit         known [DEPTH];

   always #5 clk = ~clk;

   multiport_byte_memory #(
      .DATA_W(DW), .ADDR_W(AW), .DEPTH_BYTES(DEPTH), .NUM_RD(NRD), .BYTES_PER_CYCLE(BPC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_valid(wr_valid), .wr_bytes(wr_bytes), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_busy(wr_busy), .wr_done(wr_done), .wr_fault(wr_fault)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] model_word(input int a);
      logic [31:0] w;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = mm[(a + i) % DEPTH];
      return w;
   endfunction

   function automatic bit model_known(input int a);
      bit k = 1'b1;
      for (int i = 0; i < 4; i++) k &= known[(a + i) % DEPTH];
      return k;
   endfunction

   function automatic bit model_fault(input int nb, input int a);
      bit legal = (nb == 1) || (nb == 2) || (nb == 4);
      if (!legal) return 1'b1;
      return MIS && ((a % nb) != 0);
   endfunction

   task automatic model_commit(input int nb, input int a, input logic [31:0] d);
      for (int i = 0; i < nb; i++) begin
         mm[(a + i) % DEPTH]    = d[8*i +: 8];
         known[(a + i) % DEPTH] = 1'b1;
      end
   endtask

   task automatic do_write(input int nb, input int a, input logic [31:0] d, input string tag);
      bit ef;
      int ec;
      int cnt;
      ef  = model_fault(nb, a);
      ec  = ef ? 0 : (nb + BPC - 1) / BPC;
      cnt = 0;
      wr_valid = 1'b1; wr_bytes = 3'(nb); wr_addr = 32'(a); wr_data = d;
      @(posedge clk); #1;
      // Scramble inputs: the engine must use its latched copy.
      wr_valid = 1'b0; wr_bytes = 3'($urandom); wr_addr = $urandom; wr_data = $urandom;
      chk({tag, " busy"}, 64'(wr_busy), 64'd1);
      while (!wr_done && cnt < 40) begin
         @(posedge clk); #1;
         cnt++;
      end
      chk({tag, " cycles"}, 64'(cnt), 64'(ec));
      chk({tag, " fault"}, 64'(wr_fault), 64'(ef));
      if (!ef) model_commit(nb, a, d);
      @(posedge clk); #1;
      chk({tag, " idle"}, 64'({wr_busy, wr_done}), 64'd0);
   endtask

   task automatic do_read(input int a0, input int a1, output logic [31:0] r0, output logic [31:0] r1);
      rd_addr[0] = 32'(a0); rd_addr[1] = 32'(a1);
      @(posedge clk); #1;
      r0 = rd_data[0]; r1 = rd_data[1];
   endtask

   task automatic read_vs_model(input int a0, input int a1, input string tag);
      logic [31:0] r0, r1;
      do_read(a0, a1, r0, r1);
      if (model_known(a0)) chk({tag, " rd0"}, 64'(r0), 64'(model_word(a0)));
      if (model_known(a1)) chk({tag, " rd1"}, 64'(r1), 64'(model_word(a1)));
   endtask

   typedef struct {
      int          nb;
      int          a;
      logic [31:0] d;
      int          ra0;
      int          ra1;
      logic [31:0] e0;
      logic [31:0] e1;
   } vec_t;

   vec_t vt [9];

   initial begin
      #5_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] r0, r1;
      bit          seen;

      vt[0] = '{4, 'h104, 32'h0000_0000, 'h104, 'h104, 32'h0000_0000, 32'h0000_0000};
      vt[1] = '{4, 'h100, 32'hffff_ffff, 'h100, 'h104, 32'hffff_ffff, 32'h0000_0000};
      vt[2] = '{1, 'h100, 32'h0000_0000, 'h100, 'h104, 32'hffff_ff00, 32'h0000_0000};
      vt[3] = '{2, 'h100, 32'h0000_0000, 'h100, 'h104, 32'hffff_0000, 32'h0000_0000};
      vt[4] = '{4, 'h104, 32'hdead_beef, 'h100, 'h104, 32'hffff_0000, 32'hdead_beef};
      vt[5] = '{2, 'h104, 32'hb0ba_cafe, 'h100, 'h104, 32'hffff_0000, 32'hdead_cafe};
      vt[6] = '{4, 'h100, 32'h0000_0000, 'h100, 'h104, 32'h0000_0000, 32'hdead_cafe};
`ifdef MEM_MISALIGN_FAULT_EN
      vt[7] = '{4, 'h101, 32'haabb_ccdd, 'h100, 'h104, 32'h0000_0000, 32'hdead_cafe};
`else
      vt[7] = '{4, 'h101, 32'haabb_ccdd, 'h100, 'h104, 32'hbbcc_dd00, 32'hdead_caaa};
`endif
      vt[8] = '{3, 'h100, 32'h1234_5678, 'h100, 'h104, vt[7].e0, vt[7].e1};

      for (int i = 0; i < DEPTH; i++) begin mm[i] = '0; known[i] = 1'b0; end
      wr_valid = 1'b0; wr_bytes = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("reset rd0", 64'(rd_data[0]), 64'd0);
      chk("reset rd1", 64'(rd_data[1]), 64'd0);
      chk("reset busy/done/fault", 64'({wr_busy, wr_done, wr_fault}), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed vector table
      for (int i = 0; i < 9; i++) begin
         do_write(vt[i].nb, vt[i].a, vt[i].d, $sformatf("vec%0d", i));
         do_read(vt[i].ra0, vt[i].ra1, r0, r1);
         chk($sformatf("vec%0d rd0", i), 64'(r0), 64'(vt[i].e0));
         chk($sformatf("vec%0d rd1", i), 64'(r1), 64'(vt[i].e1));
      end

      // Zero-byte request held: never busy, never done
      seen = 1'b0;
      wr_valid = 1'b1; wr_bytes = 3'd0; wr_addr = 32'h100; wr_data = 32'hffff_ffff;
      repeat (10) begin
         @(posedge clk); #1;
         if (wr_done || wr_busy) seen = 1'b1;
      end
      wr_valid = 1'b0;
      chk("zero-byte no-op", 64'(seen), 64'd0);
      do_read('h100, 'h104, r0, r1);
      chk("zero-byte mem", 64'(r0), 64'(vt[7].e0));

      // Top-of-memory wrap
      do_write(4, 0, 32'h0, "clr0");
      do_write(4, DEPTH - 4, 32'h0, "clrtop");
      do_write(4, DEPTH - 2, 32'h1122_3344, "wrap");
      read_vs_model(DEPTH - 2, 0, "wrap");
`ifndef MEM_MISALIGN_FAULT_EN
      do_read(DEPTH - 2, 0, r0, r1);
      chk("wrap rd0 const", 64'(r0), 64'h1122_3344);
      chk("wrap rd1 const", 64'(r1), 64'h0000_1122);
`endif

      // Reset after two of four commits: first two bytes stay
      do_write(4, 'h200, 32'h0, "clr200");
      wr_valid = 1'b1; wr_bytes = 3'd4; wr_addr = 32'h200; wr_data = 32'ha1b2_c3d4;
      @(posedge clk); #1;
      wr_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midreset busy", 64'(wr_busy), 64'd0);
      chk("midreset rd0", 64'(rd_data[0]), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_commit(2, 'h200, 32'h0000_c3d4);
      do_read('h200, 'h1fe, r0, r1);
      chk("midreset kept", 64'(r0), 64'h0000_c3d4);

      // Randomized writes/reads in a few windows
      for (int a = 'h300; a < 'h340; a += 4) do_write(4, a, 32'h0, "init");
      do_write(4, 4, 32'h0, "init4");
      do_write(4, DEPTH - 8, 32'h0, "initff8");
      for (int n = 0; n < 150; n++) begin
         int nb, a, ra0, ra1;
         nb  = $urandom_range(1, 7);
         a   = ($urandom_range(0, 1) == 0) ? ('h300 + $urandom_range(0, 'h3c))
                                           : ((DEPTH - 8 + $urandom_range(0, 12)) % DEPTH);
         do_write(nb, a, $urandom, $sformatf("rnd%0d", n));
         ra0 = 'h300 + $urandom_range(0, 'h3c);
         ra1 = (DEPTH - 8 + $urandom_range(0, 12)) % DEPTH;
         read_vs_model(ra0, ra1, $sformatf("rnd%0d", n));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
